// File: rtl/apb_cfg_regs_if.sv
// ---------------------------------------------------------------------------
// apb_cfg_regs_if
//
// APB bus bundle used by the configuration register block.
//
// Signals
//   PADDR   - transfer address (requester -> completer)
//   PWRITE  - 1 = write, 0 = read (requester -> completer)
//   PSEL    - completer select (requester -> completer)
//   PENABLE - access phase qualifier (requester -> completer)
//   PWDATA  - write data (requester -> completer)
//   PRDATA  - read data, held until the next read commit (completer -> requester)
//   PREADY  - registered high while the completer is in its access state
//
// Modports
//   master - requester side (testbench / interconnect)
//   slave  - completer side (apb_cfg_regs)
// ---------------------------------------------------------------------------
interface apb_cfg_regs_if #(
   parameter int REG_ADDRWIDTH = 8,
   parameter int REG_DATAWIDTH = 32
);
   logic [REG_ADDRWIDTH-1:0] PADDR;
   logic                     PWRITE;
   logic                     PSEL;
   logic                     PENABLE;
   logic [REG_DATAWIDTH-1:0] PWDATA;
   logic [REG_DATAWIDTH-1:0] PRDATA;
   logic                     PREADY;

   modport master (
      output PADDR,
      output PWRITE,
      output PSEL,
      output PENABLE,
      output PWDATA,
      input  PRDATA,
      input  PREADY
   );

   modport slave (
      input  PADDR,
      input  PWRITE,
      input  PSEL,
      input  PENABLE,
      input  PWDATA,
      output PRDATA,
      output PREADY
   );
endinterface

// File: rtl/apb_cfg_regs.sv
// ---------------------------------------------------------------------------
// apb_cfg_regs
//
// APB-programmable configuration registers for the TPU datapath: block
// enables, normalization constants, matrix base addresses and the TPU
// start/done handshake.
//
// Ports
//   clk               - sole clock, rising edge
//   reset             - synchronous, active-high reset
//   apb               - APB completer (apb_cfg_regs_if.slave)
//   enable_matmul     - ENABLES[0]
//   enable_norm       - ENABLES[1]
//   enable_pool       - ENABLES[2]
//   enable_activation - ENABLES[3]
//   mean, inv_var     - normalization constants (DWIDTH bits)
//   address_mat_a/b/c - matrix base addresses (AWIDTH bits)
//   start_tpu         - stored start bit of STDN_TPU
//   done_tpu          - TPU completion indication, captured into sticky done
//
// Register map
//   0x00 STDN_TPU  bit0 start (rw), bit31 done (ro, sticky)
//   0x04 MEAN      [DWIDTH-1:0]
//   0x08 INV_VAR   [DWIDTH-1:0]
//   0x0C MATRIX_A  [AWIDTH-1:0]
//   0x10 MATRIX_B  [AWIDTH-1:0]
//   0x14 MATRIX_C  [AWIDTH-1:0]
//   0x20 ENABLES   bit0 matmul, bit1 norm, bit2 pool, bit3 activation
//   Unmapped addresses: writes ignored, reads return 0.
// ---------------------------------------------------------------------------
module apb_cfg_regs #(
   parameter int REG_ADDRWIDTH = 8,
   parameter int REG_DATAWIDTH = 32,
   parameter int AWIDTH        = 10,
   parameter int DWIDTH        = 8
) (
   input  logic              clk,
   input  logic              reset,
   apb_cfg_regs_if.slave     apb,
   output logic              enable_matmul,
   output logic              enable_norm,
   output logic              enable_pool,
   output logic              enable_activation,
   output logic [DWIDTH-1:0] mean,
   output logic [DWIDTH-1:0] inv_var,
   output logic [AWIDTH-1:0] address_mat_a,
   output logic [AWIDTH-1:0] address_mat_b,
   output logic [AWIDTH-1:0] address_mat_c,
   output logic              start_tpu,
   input  logic              done_tpu
);

   localparam logic [REG_ADDRWIDTH-1:0] ADDR_STDN    = REG_ADDRWIDTH'(8'h00);
   localparam logic [REG_ADDRWIDTH-1:0] ADDR_MEAN    = REG_ADDRWIDTH'(8'h04);
   localparam logic [REG_ADDRWIDTH-1:0] ADDR_INV_VAR = REG_ADDRWIDTH'(8'h08);
   localparam logic [REG_ADDRWIDTH-1:0] ADDR_MAT_A   = REG_ADDRWIDTH'(8'h0C);
   localparam logic [REG_ADDRWIDTH-1:0] ADDR_MAT_B   = REG_ADDRWIDTH'(8'h10);
   localparam logic [REG_ADDRWIDTH-1:0] ADDR_MAT_C   = REG_ADDRWIDTH'(8'h14);
   localparam logic [REG_ADDRWIDTH-1:0] ADDR_ENABLES = REG_ADDRWIDTH'(8'h20);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   apb_state_e               state_q, state_d;
   logic                     pready_q, pready_d;
   logic [REG_DATAWIDTH-1:0] prdata_q, prdata_d;

   logic                     start_q, start_d;
   logic                     done_q, done_d;
   logic [3:0]               enables_q, enables_d;
   logic [DWIDTH-1:0]        mean_q, mean_d;
   logic [DWIDTH-1:0]        inv_var_q, inv_var_d;
   logic [AWIDTH-1:0]        mat_a_q, mat_a_d;
   logic [AWIDTH-1:0]        mat_b_q, mat_b_d;
   logic [AWIDTH-1:0]        mat_c_q, mat_c_d;

   logic                     commit_s;
   logic                     wr_commit_s;
   logic                     rd_commit_s;
   logic                     wr_stdn_s;
   logic [REG_DATAWIDTH-1:0] rdata_s;
   logic                     pwdata_unused_s;

   // Only the low bits of PWDATA feed registers; fold the rest so the full
   // bus is visibly consumed.
   assign pwdata_unused_s = ^apb.PWDATA;

   // APB FSM next state and commit strobe. PSEL low always returns to IDLE
   // without a commit, so a lone PENABLE never does anything.
   always_comb begin
      state_d  = state_q;
      commit_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (apb.PSEL) begin
               state_d = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (!apb.PSEL) begin
               state_d = ST_IDLE;
            end else if (apb.PENABLE) begin
               commit_s = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_ACCESS;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign wr_commit_s = commit_s & apb.PWRITE;
   assign rd_commit_s = commit_s & ~apb.PWRITE;
   assign wr_stdn_s   = wr_commit_s & (apb.PADDR == ADDR_STDN);

   // PREADY is registered so it is high exactly while the FSM sits in ACCESS.
   always_comb begin
      pready_d = (state_d == ST_ACCESS);
   end

   // Read mux: unused upper bits and unmapped addresses return zero.
   always_comb begin
      rdata_s = {REG_DATAWIDTH{1'b0}};
      case (apb.PADDR)
         ADDR_STDN: begin
            rdata_s[0]               = start_q;
            rdata_s[REG_DATAWIDTH-1] = done_q;
         end
         ADDR_MEAN:    rdata_s = REG_DATAWIDTH'(mean_q);
         ADDR_INV_VAR: rdata_s = REG_DATAWIDTH'(inv_var_q);
         ADDR_MAT_A:   rdata_s = REG_DATAWIDTH'(mat_a_q);
         ADDR_MAT_B:   rdata_s = REG_DATAWIDTH'(mat_b_q);
         ADDR_MAT_C:   rdata_s = REG_DATAWIDTH'(mat_c_q);
         ADDR_ENABLES: rdata_s = REG_DATAWIDTH'(enables_q);
         default:      rdata_s = {REG_DATAWIDTH{1'b0}};
      endcase
   end

   // PRDATA only changes on a read commit and otherwise holds.
   always_comb begin
      if (rd_commit_s) begin
         prdata_d = rdata_s;
      end else begin
         prdata_d = prdata_q;
      end
   end

   // Write decode for the configuration registers; upper write bits dropped.
   always_comb begin
      start_d   = start_q;
      enables_d = enables_q;
      mean_d    = mean_q;
      inv_var_d = inv_var_q;
      mat_a_d   = mat_a_q;
      mat_b_d   = mat_b_q;
      mat_c_d   = mat_c_q;
      if (wr_commit_s) begin
         case (apb.PADDR)
            ADDR_STDN:    start_d   = apb.PWDATA[0];
            ADDR_MEAN:    mean_d    = apb.PWDATA[DWIDTH-1:0];
            ADDR_INV_VAR: inv_var_d = apb.PWDATA[DWIDTH-1:0];
            ADDR_MAT_A:   mat_a_d   = apb.PWDATA[AWIDTH-1:0];
            ADDR_MAT_B:   mat_b_d   = apb.PWDATA[AWIDTH-1:0];
            ADDR_MAT_C:   mat_c_d   = apb.PWDATA[AWIDTH-1:0];
            ADDR_ENABLES: enables_d = apb.PWDATA[3:0];
            default: begin
               start_d = start_q;
            end
         endcase
      end else begin
         start_d = start_q;
      end
   end

   // Sticky done: any write to STDN_TPU clears it and beats a same-edge
   // done_tpu; otherwise done_tpu while started sets it, and it then holds.
   always_comb begin
      if (wr_stdn_s) begin
         done_d = 1'b0;
      end else if (done_tpu && start_q) begin
         done_d = 1'b1;
      end else begin
         done_d = done_q;
      end
   end

   // State and register storage with synchronous reset; reset also aborts
   // any transfer in flight since it overrides the commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pready_q  <= 1'b0;
         prdata_q  <= {REG_DATAWIDTH{1'b0}};
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         enables_q <= 4'd0;
         mean_q    <= {DWIDTH{1'b0}};
         inv_var_q <= {DWIDTH{1'b0}};
         mat_a_q   <= {AWIDTH{1'b0}};
         mat_b_q   <= {AWIDTH{1'b0}};
         mat_c_q   <= {AWIDTH{1'b0}};
      end else begin
         state_q   <= state_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         start_q   <= start_d;
         done_q    <= done_d;
         enables_q <= enables_d;
         mean_q    <= mean_d;
         inv_var_q <= inv_var_d;
         mat_a_q   <= mat_a_d;
         mat_b_q   <= mat_b_d;
         mat_c_q   <= mat_c_d;
      end
   end

   assign apb.PREADY        = pready_q;
   assign apb.PRDATA        = prdata_q;
   assign enable_matmul     = enables_q[0];
   assign enable_norm       = enables_q[1];
   assign enable_pool       = enables_q[2];
   assign enable_activation = enables_q[3];
   assign mean              = mean_q;
   assign inv_var           = inv_var_q;
   assign address_mat_a     = mat_a_q;
   assign address_mat_b     = mat_b_q;
   assign address_mat_c     = mat_c_q;
   assign start_tpu         = start_q;

endmodule

// File: tb/tb_apb_cfg_regs.sv
// ---------------------------------------------------------------------------
// tb_apb_cfg_regs
//
// Directed bench for apb_cfg_regs: a table of APB transfers with expected
// read data and expected output snapshots, followed by hand-written
// sequences for the done handshake, stalled/aborted transfers and reset.
// ---------------------------------------------------------------------------
module tb_apb_cfg_regs;

   logic       clk;
   logic       reset;
   logic       done_tpu;
   logic       enable_matmul, enable_norm, enable_pool, enable_activation;
   logic [7:0] mean, inv_var;
   logic [9:0] address_mat_a, address_mat_b, address_mat_c;
   logic       start_tpu;

   int n_checks;
   int n_errors;

   apb_cfg_regs_if #(.REG_ADDRWIDTH(8), .REG_DATAWIDTH(32)) bus ();

   apb_cfg_regs #(
      .REG_ADDRWIDTH(8),
      .REG_DATAWIDTH(32),
      .AWIDTH(10),
      .DWIDTH(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .apb(bus),
      .enable_matmul(enable_matmul),
      .enable_norm(enable_norm),
      .enable_pool(enable_pool),
      .enable_activation(enable_activation),
      .mean(mean),
      .inv_var(inv_var),
      .address_mat_a(address_mat_a),
      .address_mat_b(address_mat_b),
      .address_mat_c(address_mat_c),
      .start_tpu(start_tpu),
      .done_tpu(done_tpu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      logic [50:0] exp_outs;
   } vec_t;

   vec_t vecs[18];

   function automatic logic [50:0] pack_outs(input logic st, input logic [3:0] en,
                                             input logic [7:0] m, input logic [7:0] iv,
                                             input logic [9:0] a, input logic [9:0] b,
                                             input logic [9:0] c);
      return {st, en, m, iv, a, b, c};
   endfunction

   function automatic vec_t mk(input logic wr, input logic [7:0] addr,
                               input logic [31:0] data, input logic [31:0] exp_rd,
                               input logic [50:0] exp_outs);
      vec_t v;
      v.wr = wr; v.addr = addr; v.data = data; v.exp_rd = exp_rd; v.exp_outs = exp_outs;
      return v;
   endfunction

   function automatic logic [50:0] cur_outs();
      return {start_tpu, enable_activation, enable_pool, enable_norm, enable_matmul,
              mean, inv_var, address_mat_a, address_mat_b, address_mat_c};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Full APB transfer; returns at #1 after the commit edge with the bus idle.
   task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data);
      int n;
      @(negedge clk);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
      bus.PADDR = addr; bus.PWDATA = data;
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      n = 0;
      while (bus.PREADY !== 1'b1 && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      n_checks++;
      if (bus.PREADY !== 1'b1) begin
         n_errors++;
         $display("FAIL pready_timeout: got 0x%0h expected 0x1", bus.PREADY);
      end
      @(posedge clk); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] last_rd;
      n_checks = 0; n_errors = 0;
      reset = 1'b1; done_tpu = 1'b0;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = 8'h00; bus.PWDATA = 32'h0;

      vecs[0]  = mk(1'b1, 8'h20, 32'h0000_000D, 32'h0, pack_outs(1'b0, 4'hD, 8'h00, 8'h00, 10'h000, 10'h000, 10'h000));
      vecs[1]  = mk(1'b0, 8'h20, 32'h0,         32'h0000_000D, pack_outs(1'b0, 4'hD, 8'h00, 8'h00, 10'h000, 10'h000, 10'h000));
      vecs[2]  = mk(1'b1, 8'h04, 32'h0000_01FF, 32'h0, pack_outs(1'b0, 4'hD, 8'hFF, 8'h00, 10'h000, 10'h000, 10'h000));
      vecs[3]  = mk(1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0, pack_outs(1'b0, 4'hD, 8'hFF, 8'h00, 10'h3FF, 10'h000, 10'h000));
      vecs[4]  = mk(1'b0, 8'h0C, 32'h0,         32'h0000_03FF, pack_outs(1'b0, 4'hD, 8'hFF, 8'h00, 10'h3FF, 10'h000, 10'h000));
      vecs[5]  = mk(1'b0, 8'h04, 32'h0,         32'h0000_00FF, pack_outs(1'b0, 4'hD, 8'hFF, 8'h00, 10'h3FF, 10'h000, 10'h000));
      vecs[6]  = mk(1'b1, 8'h08, 32'h0000_00A5, 32'h0, pack_outs(1'b0, 4'hD, 8'hFF, 8'hA5, 10'h3FF, 10'h000, 10'h000));
      vecs[7]  = mk(1'b0, 8'h08, 32'h0,         32'h0000_00A5, pack_outs(1'b0, 4'hD, 8'hFF, 8'hA5, 10'h3FF, 10'h000, 10'h000));
      vecs[8]  = mk(1'b1, 8'h10, 32'h0000_0123, 32'h0, pack_outs(1'b0, 4'hD, 8'hFF, 8'hA5, 10'h3FF, 10'h123, 10'h000));
      vecs[9]  = mk(1'b1, 8'h14, 32'hFFFF_F2AA, 32'h0, pack_outs(1'b0, 4'hD, 8'hFF, 8'hA5, 10'h3FF, 10'h123, 10'h2AA));
      vecs[10] = mk(1'b0, 8'h14, 32'h0,         32'h0000_02AA, pack_outs(1'b0, 4'hD, 8'hFF, 8'hA5, 10'h3FF, 10'h123, 10'h2AA));
      vecs[11] = mk(1'b0, 8'h10, 32'h0,         32'h0000_0123, pack_outs(1'b0, 4'hD, 8'hFF, 8'hA5, 10'h3FF, 10'h123, 10'h2AA));
      vecs[12] = mk(1'b1, 8'h30, 32'hFFFF_FFFF, 32'h0, pack_outs(1'b0, 4'hD, 8'hFF, 8'hA5, 10'h3FF, 10'h123, 10'h2AA));
      vecs[13] = mk(1'b0, 8'h30, 32'h0,         32'h0000_0000, pack_outs(1'b0, 4'hD, 8'hFF, 8'hA5, 10'h3FF, 10'h123, 10'h2AA));
      vecs[14] = mk(1'b1, 8'h20, 32'h0000_0002, 32'h0, pack_outs(1'b0, 4'h2, 8'hFF, 8'hA5, 10'h3FF, 10'h123, 10'h2AA));
      vecs[15] = mk(1'b0, 8'h18, 32'h0,         32'h0000_0000, pack_outs(1'b0, 4'h2, 8'hFF, 8'hA5, 10'h3FF, 10'h123, 10'h2AA));
      vecs[16] = mk(1'b0, 8'h00, 32'h0,         32'h0000_0000, pack_outs(1'b0, 4'h2, 8'hFF, 8'hA5, 10'h3FF, 10'h123, 10'h2AA));
      vecs[17] = mk(1'b0, 8'h20, 32'h0,         32'h0000_0002, pack_outs(1'b0, 4'h2, 8'hFF, 8'hA5, 10'h3FF, 10'h123, 10'h2AA));

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_pready", {63'd0, bus.PREADY}, 64'd0);
      check("rst_prdata", {32'd0, bus.PRDATA}, 64'd0);
      check("rst_outs", {13'd0, cur_outs()}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven transfers
      last_rd = 32'h0;
      for (int i = 0; i < 18; i++) begin
         apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data);
         if (!vecs[i].wr) last_rd = vecs[i].exp_rd;
         check($sformatf("vec%0d_prdata", i), {32'd0, bus.PRDATA}, {32'd0, last_rd});
         check($sformatf("vec%0d_outs", i), {13'd0, cur_outs()}, {13'd0, vecs[i].exp_outs});
         check($sformatf("vec%0d_pready_idle", i), {63'd0, bus.PREADY}, 64'd0);
      end

      // Start, one-cycle done pulse, sticky done, clear by write
      apb_xfer(1'b1, 8'h00, 32'h0000_0001);
      check("start_set", {63'd0, start_tpu}, 64'd1);
      @(negedge clk); done_tpu = 1'b1;
      @(negedge clk); done_tpu = 1'b0;
      repeat (2) @(posedge clk);
      apb_xfer(1'b0, 8'h00, 32'h0);
      check("done_sticky_rd", {32'd0, bus.PRDATA}, 64'h8000_0001);
      apb_xfer(1'b1, 8'h00, 32'h0000_0000);
      check("start_clr", {63'd0, start_tpu}, 64'd0);
      apb_xfer(1'b0, 8'h00, 32'h0);
      check("stdn_cleared_rd", {32'd0, bus.PRDATA}, 64'd0);

      // Write to STDN_TPU with done_tpu held: clear wins, set on next edge
      apb_xfer(1'b1, 8'h00, 32'h0000_0001);
      @(negedge clk); done_tpu = 1'b1;
      @(posedge clk); #1;
      check("done_pre", {63'd0, dut.done_q}, 64'd1);
      apb_xfer(1'b1, 8'h00, 32'h8000_0001);
      check("done_clear_wins", {63'd0, dut.done_q}, 64'd0);
      @(posedge clk); #1;
      check("done_reset_next", {63'd0, dut.done_q}, 64'd1);
      apb_xfer(1'b0, 8'h00, 32'h0);
      check("done_held_rd", {32'd0, bus.PRDATA}, 64'h8000_0001);
      @(negedge clk); done_tpu = 1'b0;
      apb_xfer(1'b1, 8'h00, 32'h0000_0000);
      check("start_clr2", {63'd0, start_tpu}, 64'd0);

      // ACCESS stall with PENABLE low, then PSEL dropped: no commit
      @(negedge clk);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
      bus.PADDR = 8'h10; bus.PWDATA = 32'h0000_03FF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("stall_pready", {63'd0, bus.PREADY}, 64'd1);
      @(posedge clk); #1;
      check("stall_pready_hold", {63'd0, bus.PREADY}, 64'd1);
      check("stall_no_commit", {54'd0, address_mat_b}, 64'h123);
      bus.PSEL = 1'b0; bus.PENABLE = 1'b1;
      @(posedge clk); #1;
      check("drop_pready", {63'd0, bus.PREADY}, 64'd0);
      check("drop_no_commit", {54'd0, address_mat_b}, 64'h123);

      // PENABLE without PSEL is ignored
      repeat (3) @(posedge clk);
      #1;
      check("lone_penable_pready", {63'd0, bus.PREADY}, 64'd0);
      check("lone_penable_b", {54'd0, address_mat_b}, 64'h123);
      bus.PENABLE = 1'b0;
      apb_xfer(1'b0, 8'h10, 32'h0);
      check("after_drop_rd", {32'd0, bus.PRDATA}, 64'h123);

      // Reset during ACCESS of write 0x10 = 5
      @(negedge clk);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
      bus.PADDR = 8'h10; bus.PWDATA = 32'h0000_0005;
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      @(posedge clk); #1;
      check("rst_acc_pready", {63'd0, bus.PREADY}, 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_acc_b", {54'd0, address_mat_b}, 64'd0);
      check("rst_acc_pready0", {63'd0, bus.PREADY}, 64'd0);
      check("rst_acc_prdata", {32'd0, bus.PRDATA}, 64'd0);
      check("rst_acc_outs", {13'd0, cur_outs()}, 64'd0);
      reset = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      @(posedge clk); #1;
      check("post_rst_b", {54'd0, address_mat_b}, 64'd0);
      check("post_rst_pready", {63'd0, bus.PREADY}, 64'd0);
      apb_xfer(1'b0, 8'h10, 32'h0);
      check("post_rst_rd", {32'd0, bus.PRDATA}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/apb_cfg_regs.md
APB_CFG_REGS -- requirements
Module: apb_cfg_regs

Interface
REQ-001 SHALL have parameter REG_ADDRWIDTH, default 8: APB address width.
REQ-002 SHALL have parameter REG_DATAWIDTH, default 32: APB data width.
REQ-003 SHALL have parameter AWIDTH, default 10: BRAM address width of matrix base-address outputs.
REQ-004 SHALL have parameter DWIDTH, default 8: width of the mean and inv_var outputs.
REQ-005 SHALL have port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have ports PADDR input REG_ADDRWIDTH, PWRITE input 1, PSEL input 1, PENABLE input 1, PWDATA input REG_DATAWIDTH: APB requester signals.
REQ-008 SHALL have ports PRDATA output REG_DATAWIDTH and PREADY output 1: APB completer response.
REQ-009 SHALL have outputs enable_matmul, enable_norm, enable_pool, enable_activation, each 1: block enables.
REQ-010 SHALL have outputs mean and inv_var, each DWIDTH: normalization constants.
REQ-011 SHALL have outputs address_mat_a, address_mat_b, address_mat_c, each AWIDTH: matrix base addresses.
REQ-012 SHALL have output start_tpu, 1, and input done_tpu, 1: TPU start level and done indication.

Function
REQ-013 Address map SHALL be: 0x00 STDN_TPU, 0x04 MEAN, 0x08 INV_VAR, 0x0C MATRIX_A, 0x10 MATRIX_B, 0x14 MATRIX_C, 0x20 ENABLES.
REQ-014 ENABLES SHALL map bit0 matmul, bit1 norm, bit2 pool, bit3 activation.
REQ-015 STDN_TPU SHALL map bit0 start (read/write) and bit31 done (read-only, sticky).
REQ-016 MEAN/INV_VAR SHALL use bits [DWIDTH-1:0]; MATRIX_x SHALL use bits [AWIDTH-1:0]; unused bits are ignored on write and read as 0.
REQ-017 APB FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-018 IDLE->SETUP when PSEL=1; IDLE otherwise.
REQ-019 SETUP->ACCESS unconditionally on the next edge; PREADY SHALL be a registered 1 only while in ACCESS.
REQ-020 In ACCESS with PSEL=1 and PENABLE=1 the transfer SHALL commit on that edge and return to IDLE.
REQ-021 In ACCESS with PSEL=1 and PENABLE=0 the FSM SHALL remain in ACCESS; with PSEL=0 it SHALL return to IDLE with no commit.
REQ-022 Write commit SHALL update the addressed register; new value visible on outputs the cycle after the commit edge.
REQ-023 Read commit SHALL load PRDATA with the addressed register; PRDATA SHALL hold until the next read commit.
REQ-024 Writes to unmapped addresses SHALL be ignored; reads from them SHALL return 0.
REQ-025 done bit SHALL set on any edge where done_tpu=1 and start=1, and stay set while start=1.
REQ-026 Any committed write to STDN_TPU SHALL clear done; if done_tpu=1 on the same edge, the clear wins.
REQ-027 Writes to bit31 of STDN_TPU SHALL have no effect; start_tpu SHALL equal the stored start bit.
REQ-028 PENABLE=1 with PSEL=0 SHALL be ignored in every state.

Reset
REQ-029 On reset=1 at an edge, FSM SHALL go to IDLE and PREADY, PRDATA, start_tpu, done, all enables, mean, inv_var and all addresses SHALL be 0.
REQ-030 Reset mid-transaction SHALL abort it with no register update.

Verification
REQ-031 Write 0x20=0x0000_000D, read 0x20 -> enable_matmul=1, enable_norm=0, enable_pool=1, enable_activation=1, PRDATA=0x0000_000D.
REQ-032 Write 0x04=0x1FF, 0x0C=0xFFFF_FFFF -> mean=0xFF; address_mat_a=0x3FF; read 0x0C returns 0x0000_03FF.
REQ-033 Write 0x00=1, pulse done_tpu one cycle, poll 0x00 -> reads 0x8000_0001; write 0x00=0 -> start_tpu=0, read 0x00 = 0.
REQ-034 done_tpu=1 held, write 0x00=1 on same edge as done set -> done clear, then set next edge; read returns 0x8000_0001.
REQ-035 Read 0x30 -> PRDATA=0; write 0x30 -> no register changes; PSEL dropped in ACCESS -> no commit, FSM IDLE.
REQ-036 Assert reset during ACCESS of write 0x10=0x5 -> address_mat_b stays 0, PREADY=0, FSM IDLE.
